pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  Parametrised program-counter and instruction-fetch engine for the multicycle RISC-V core.
//  Owns the PC, issues handshaked fetches to instruction memory with wait states, and latches the instruction word.
//  Resolves PC redirects: sequential, absolute jump, and the full compare set beq/bne/blt/bge/bltu/bgeu.
//  Flags misaligned targets and memory timeouts. Sits between the control FSM and the instruction memory, ahead of the instruction register.
// PARAMETERS
//  XLEN          64   datapath / PC width in bits (>= 32)
//  RESET_VECTOR  0    PC value after reset (XLEN bits, 4-byte aligned)
//  TIMEOUT       16   max cycles in WAIT without imem_ack before error (>= 2)
// PORTS
//  clk          in   1     rising-edge clock
//  reset        in   1     synchronous, active-high reset
//  fetch_req    in   1     control requests a fetch at the current pc
//  imem_req     out  1     fetch request to instruction memory
//  imem_addr    out  XLEN  fetch address (== pc while imem_req)
//  imem_ack     in   1     memory returns imem_rdata this cycle
//  imem_rdata   in   32    instruction word from memory
//  instr        out  32    last fetched instruction (held)
//  instr_valid  out  1     one-cycle pulse: instr newly updated
//  pc           out  XLEN  current PC
//  pc_plus4     out  XLEN  pc + 4 (combinational, mod 2^XLEN)
//  pc_upd       in   1     apply a PC update this cycle
//  pc_upd_kind  in   2     00 seq (pc+4), 01 jump (target), 10 cond branch, 11 reserved (no-op)
//  br_cond      in   3     funct3: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; others = not taken
//  cmp_a        in   XLEN  branch compare operand A (rs1)
//  cmp_b        in   XLEN  branch compare operand B (rs2)
//  target       in   XLEN  jump/branch target address
//  busy         out  1     high in WAIT and ERR
//  misalign     out  1     one-cycle pulse: redirect rejected, target[1:0] != 0
//  timeout_err  out  1     sticky: memory never acknowledged; cleared only by reset
// BEHAVIOUR
//  Reset (sync, wins over all inputs): pc = RESET_VECTOR, instr = 0, state IDLE. All 1-bit outputs 0.
//  States: IDLE, WAIT, ERR.
//  IDLE: imem_req = 0.
//   - pc_upd = 1: apply the update, stay in IDLE; fetch_req is ignored that cycle.
//   - else fetch_req = 1: go to WAIT; counter = 0.
//  WAIT: imem_req = 1; imem_addr = pc. pc_upd and fetch_req are ignored (no PC change, no pulse).
//   - imem_ack = 1: instr <= imem_rdata; instr_valid = 1 the next cycle; go to IDLE.
//     Fetch latency is ack cycle + 1.
//   - ack in the first WAIT cycle: instr_valid rises 2 cycles after fetch_req.
//   - counter increments each cycle without ack; if counter == TIMEOUT-1 and no ack: go to ERR.
//  ERR: timeout_err = 1 and busy = 1 until reset; imem_req = 0; all requests ignored.
//  PC update (IDLE only), next pc:
//   - seq:    pc + 4, wraps mod 2^XLEN.
//   - jump:   target.
//   - branch: target if cond holds, else pc + 4.
//   - lt/ge are signed XLEN compares; ltu/geu are unsigned.
//   - taken jump or branch with target[1:0] != 0: pc unchanged, misalign pulses 1 cycle.
//   - not-taken branch never checks alignment.
//  instr holds its value until the next ack; it is not cleared by redirects.
// TESTING
//  1. Reset, RESET_VECTOR=0x100: pc=0x100, imem_req=0, instr=0.
//     Then fetch_req, ack on 1st WAIT cycle with 0x00500093: instr=0x00500093, instr_valid pulses once.
//  2. Wait states: ack after 3 WAIT cycles: imem_addr=pc and imem_req held all 3 cycles, busy=1.
//     pc_upd(seq) during WAIT: pc unchanged.
//  3. Branches, XLEN=64, pc=0x200, target=0x180:
//     - blt with cmp_a=-1, cmp_b=1: pc=0x180.
//     - bltu with same operands: pc=0x204.
//     - bne with equal operands: pc=0x204.
//  4. jump to target=0x1002: misalign pulse, pc unchanged.
//     Seq at pc=2^64-4: pc=0.
//  5. No ack for TIMEOUT=4 cycles: ERR, timeout_err=1 sticky.
//     Later fetch_req and ack ignored; reset clears all.
//  6. fetch_req together with pc_upd(jump 0x40) in IDLE: pc=0x40, no imem_req.
//     Next-cycle fetch_req fetches address 0x40.

Source files
------------

// File: rtl/pc_fetch_unit.sv
//------------------------------------------------------------------------------
// Module      : pc_fetch_unit
// Description : Program counter and handshaked instruction-fetch engine with
//               branch/jump redirect resolution and memory timeout detection.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_fetch_unit #(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              TIMEOUT      = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_req,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            pc_upd,
    input  logic [1:0]      pc_upd_kind,
    input  logic [2:0]      br_cond,
    input  logic [XLEN-1:0] cmp_a,
    input  logic [XLEN-1:0] cmp_b,
    input  logic [XLEN-1:0] target,
    output logic            busy,
    output logic            misalign,
    output logic            timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    localparam logic [1:0] K_SEQ    = 2'b00;
    localparam logic [1:0] K_JUMP   = 2'b01;
    localparam logic [1:0] K_BRANCH = 2'b10;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            r_instrValid;
    logic            r_misalign;
    logic [CNT_W-1:0] r_waitCnt;

    logic [1:0]      w_stateNext;
    logic [XLEN-1:0] w_pcNext;
    logic [XLEN-1:0] w_pcPlus4;
    logic [CNT_W-1:0] w_waitCntNext;
    logic            w_misalignNext;
    logic            w_capture;
    logic            w_brTaken;
    logic            w_redirect;

    assign w_pcPlus4 = r_pc + XLEN'(4);

    always_comb begin
        w_brTaken = 1'b0;
        case (br_cond)
            3'b000:  w_brTaken = (cmp_a == cmp_b);
            3'b001:  w_brTaken = (cmp_a != cmp_b);
            3'b100:  w_brTaken = ($signed(cmp_a) <  $signed(cmp_b));
            3'b101:  w_brTaken = ($signed(cmp_a) >= $signed(cmp_b));
            3'b110:  w_brTaken = (cmp_a <  cmp_b);
            3'b111:  w_brTaken = (cmp_a >= cmp_b);
            default: w_brTaken = 1'b0;
        endcase
    end

    assign w_redirect = (pc_upd_kind == K_JUMP) || ((pc_upd_kind == K_BRANCH) && w_brTaken);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_VECTOR;
            r_instr      <= '0;
            r_instrValid <= 1'b0;
            r_misalign   <= 1'b0;
            r_waitCnt    <= '0;
        end else begin
            r_state      <= w_stateNext;
            r_pc         <= w_pcNext;
            r_instrValid <= w_capture;
            r_misalign   <= w_misalignNext;
            r_waitCnt    <= w_waitCntNext;
            if (w_capture) begin
                r_instr <= imem_rdata;
            end
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_pcNext       = r_pc;
        w_waitCntNext  = r_waitCnt;
        w_misalignNext = 1'b0;
        w_capture      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A PC update owns the cycle; a simultaneous fetch request is dropped.
                if (pc_upd) begin
                    if (w_redirect) begin
                        if (target[1:0] != 2'b00) begin
                            w_misalignNext = 1'b1;
                        end else begin
                            w_pcNext = target;
                        end
                    end else if ((pc_upd_kind == K_SEQ) || (pc_upd_kind == K_BRANCH)) begin
                        w_pcNext = w_pcPlus4;
                    end
                end else if (fetch_req) begin
                    w_stateNext   = S_WAIT;
                    w_waitCntNext = '0;
                end
            end
            S_WAIT: begin
                // An ack on the last allowed cycle still completes the fetch.
                if (imem_ack) begin
                    w_capture   = 1'b1;
                    w_stateNext = S_IDLE;
                end else if (r_waitCnt == CNT_W'(TIMEOUT - 1)) begin
                    w_stateNext = S_ERR;
                end else begin
                    w_waitCntNext = r_waitCnt + CNT_W'(1);
                end
            end
            S_ERR: begin
                w_stateNext = S_ERR;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    assign pc          = r_pc;
    assign pc_plus4    = w_pcPlus4;
    assign imem_req    = (r_state == S_WAIT);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instrValid;
    assign misalign    = r_misalign;
    assign busy        = (r_state == S_WAIT) || (r_state == S_ERR);
    assign timeout_err = (r_state == S_ERR);

endmodule

`default_nettype wire
